// File: rtl/mcp3201_pkg.sv
// Shared constants, state encoding and helpers for the MCP3201 responder.
// The falling-edge counter thresholds set the frame layout that the master sees.
package mcp3201_pkg;

  localparam int DATA_W = 12;
  localparam int FCNT_W = 5;

  localparam logic [FCNT_W-1:0] FE_NULL     = 5'd2;
  localparam logic [FCNT_W-1:0] FE_MSB_LAST = 5'd14;
  localparam logic [FCNT_W-1:0] FE_LSB_LAST = 5'd25;
  localparam logic [FCNT_W-1:0] FE_SAT      = 5'd26;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    NULL,
    MSB,
    LSB,
    TAIL
  } resp_state_t;

  // The count saturates so that long tails of SCLK cannot wrap into a new frame.
  function automatic logic [FCNT_W-1:0] fcnt_inc(input logic [FCNT_W-1:0] cnt);
    return (cnt >= FE_SAT) ? FE_SAT : cnt + 5'd1;
  endfunction

endpackage

// File: rtl/mcp3201_responder_if.sv
// SPI link between the acquisition master and the emulated MCP3201, plus the
// responder's frame status pulses.
interface mcp3201_responder_if #(
  parameter int DATA_W = 12
);
  logic              sclk_i;
  logic              cs_n_i;
  logic [DATA_W-1:0] sample_i;
  logic              dout_o;
  logic              dout_oe_o;
  logic              conv_start_o;
  logic              frame_done_o;
  logic              frame_abort_o;

  modport master (
    output sclk_i,
    output cs_n_i,
    output sample_i,
    input  dout_o,
    input  dout_oe_o,
    input  conv_start_o,
    input  frame_done_o,
    input  frame_abort_o
  );

  modport slave (
    input  sclk_i,
    input  cs_n_i,
    input  sample_i,
    output dout_o,
    output dout_oe_o,
    output conv_start_o,
    output frame_done_o,
    output frame_abort_o
  );
endinterface

// File: rtl/mcp3201_responder_sync_edge_det.sv
// Multi-stage synchronizer for one asynchronous pin followed by a registered
// edge detector; rise/fall are single-cycle pulses in the clock domain.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the pin's idle level so no phantom edge appears after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/mcp3201_responder.sv
// Emulates an MCP3201 on the slave side of the SPI link: latches a sample at
// CS_n fall and serialises null bit, MSB-first word, then LSB-first mirror.
module mcp3201_responder
  import mcp3201_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = mcp3201_pkg::DATA_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mcp3201_responder_if.slave   bus
);

  logic sclk_rise_unused;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sclk_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (bus.sclk_i),
    .rise_o  (sclk_rise_unused),
    .fall_o  (sclk_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_cs_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (bus.cs_n_i),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  resp_state_t       state_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  logic [DATA_W-1:0] shreg_q;
  logic              dout_q;
  logic              dout_oe_q;
  logic              conv_start_q;
  logic              frame_done_q;
  logic              frame_abort_q;
  logic [3:0]        msb_idx;
  logic [3:0]        lsb_idx;

  assign fcnt_d  = fcnt_inc(fcnt_q);
  assign msb_idx = 4'(FE_MSB_LAST - fcnt_d);
  assign lsb_idx = 4'(fcnt_d - FE_MSB_LAST);

  // Priority: CS_n rise, then CS_n fall, then SCLK fall (only inside a frame).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fcnt_q        <= '0;
      shreg_q       <= '0;
      dout_q        <= 1'b0;
      dout_oe_q     <= 1'b0;
      conv_start_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      conv_start_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      if (cs_rise) begin
        if (state_q != IDLE) begin
          if (fcnt_q >= FE_MSB_LAST) frame_done_q  <= 1'b1;
          else                       frame_abort_q <= 1'b1;
        end
        state_q   <= IDLE;
        fcnt_q    <= '0;
        dout_q    <= 1'b0;
        dout_oe_q <= 1'b0;
      end else if (cs_fall) begin
        state_q      <= SAMPLE;
        shreg_q      <= bus.sample_i;
        conv_start_q <= 1'b1;
        fcnt_q       <= '0;
        dout_q       <= 1'b0;
        dout_oe_q    <= 1'b0;
      end else if (sclk_fall && state_q != IDLE) begin
        fcnt_q <= fcnt_d;
        if (fcnt_d == FE_NULL) begin
          state_q   <= NULL;
          dout_oe_q <= 1'b1;
          dout_q    <= 1'b0;
        end else if (fcnt_d > FE_NULL && fcnt_d <= FE_MSB_LAST) begin
          state_q   <= MSB;
          dout_oe_q <= 1'b1;
          dout_q    <= shreg_q[msb_idx];
        end else if (fcnt_d > FE_MSB_LAST && fcnt_d <= FE_LSB_LAST) begin
          state_q   <= LSB;
          dout_oe_q <= 1'b1;
          dout_q    <= shreg_q[lsb_idx];
        end else if (fcnt_d > FE_LSB_LAST) begin
          state_q   <= TAIL;
          dout_oe_q <= 1'b1;
          dout_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.dout_o        = dout_q;
  assign bus.dout_oe_o     = dout_oe_q;
  assign bus.conv_start_o  = conv_start_q;
  assign bus.frame_done_o  = frame_done_q;
  assign bus.frame_abort_o = frame_abort_q;

endmodule

// File: tb/tb_mcp3201_responder.sv
// Scoreboard bench: expected DOUT bits are queued when a frame is launched and
// popped as the emulated master samples on each SCLK rise.
module tb_mcp3201_responder;

  localparam int HALF = 8;

  typedef struct {
    logic oe;
    logic d;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  mcp3201_responder_if #(.DATA_W(12)) bus ();

  mcp3201_responder #(
    .SYNC_STAGES (2),
    .DATA_W      (12)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   n_conv  = 0;
  int   n_done  = 0;
  int   n_abort = 0;
  int   n_oe_hi = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.conv_start_o === 1'b1)  n_conv++;
      if (bus.frame_done_o === 1'b1)  n_done++;
      if (bus.frame_abort_o === 1'b1) n_abort++;
      if (bus.dout_oe_o === 1'b1)     n_oe_hi++;
    end
  end

  task automatic clear_counts();
    n_conv  = 0;
    n_done  = 0;
    n_abort = 0;
    n_oe_hi = 0;
  endtask

  // Expected pin state after each SCLK fall: hi-Z, null, B11..B0, B1..B11, zeros.
  task automatic push_frame(input logic [11:0] s, input int nfalls);
    exp_t full[$];
    full.push_back('{1'b0, 1'b0});
    full.push_back('{1'b1, 1'b0});
    for (int b = 11; b >= 0; b--) full.push_back('{1'b1, s[b]});
    for (int b = 1; b <= 11; b++) full.push_back('{1'b1, s[b]});
    while (full.size() < nfalls) full.push_back('{1'b1, 1'b0});
    for (int k = 0; k < nfalls; k++) exp_q.push_back(full[k]);
  endtask

  task automatic drive_frame(input logic [11:0] s, input int nfalls, input int chg_at,
                             input logic [11:0] chg_val, input int rst_at, input string tag);
    exp_t e;
    $display("frame %s: sample=%03h falls=%0d", tag, s, nfalls);
    bus.sample_i = s;
    push_frame(s, nfalls);
    @(negedge clock);
    bus.cs_n_i = 1'b0;
    repeat (HALF) @(negedge clock);
    for (int i = 1; i <= nfalls + 1; i++) begin
      if (i >= 2) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL %s scoreboard underflow at fall %0d: got oe=%b d=%b, required an entry",
                   tag, i - 1, bus.dout_oe_o, bus.dout_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.dout_oe_o, bus.dout_o} !== {e.oe, e.d}) begin
            n_errors++;
            $display("FAIL %s dout after fall %0d: got oe=%b d=%b, required oe=%b d=%b",
                     tag, i - 1, bus.dout_oe_o, bus.dout_o, e.oe, e.d);
          end
        end
      end
      if (i == nfalls + 1) break;
      bus.sclk_i = 1'b1;
      repeat (HALF) @(negedge clock);
      bus.sclk_i = 1'b0;
      if (i == chg_at) bus.sample_i = chg_val;
      if (i == rst_at) return;
      repeat (HALF) @(negedge clock);
    end
    bus.cs_n_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({bus.dout_o, bus.dout_oe_o, bus.conv_start_o, bus.frame_done_o, bus.frame_abort_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {bus.dout_o, bus.dout_oe_o, bus.conv_start_o, bus.frame_done_o, bus.frame_abort_o});
    end
    reset_n = 1'b1;
    clear_counts();
    repeat (6) @(negedge clock);
    n_checks++;
    if (n_conv + n_done + n_abort + n_oe_hi != 0) begin
      n_errors++;
      $display("FAIL reset_release_quiet: got %0d active cycles, required 0",
               n_conv + n_done + n_abort + n_oe_hi);
    end
  endtask

  task automatic test_full_frame();
    clear_counts();
    drive_frame(12'hA5C, 26, 0, 12'h000, 0, "full_a5c");
    repeat (8) @(negedge clock);
    n_checks++;
    if (n_conv != 1) begin
      n_errors++;
      $display("FAIL full_conv_start: got %0d pulses, required 1", n_conv);
    end
    n_checks++;
    if (n_done != 1 || n_abort != 0) begin
      n_errors++;
      $display("FAIL full_done: got done=%0d abort=%0d, required done=1 abort=0", n_done, n_abort);
    end
    n_checks++;
    if (bus.dout_oe_o !== 1'b0) begin
      n_errors++;
      $display("FAIL full_oe_after_cs: got %b, required 0", bus.dout_oe_o);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    drive_frame(12'h3C6, 8, 0, 12'h000, 0, "abort_8");
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.dout_oe_o !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_oe_before_latency: got %b, required 1", bus.dout_oe_o);
    end
    @(negedge clock);
    n_checks++;
    if (bus.dout_oe_o !== 1'b0 || bus.frame_abort_o !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_at_latency: got oe=%b abort=%b, required oe=0 abort=1",
               bus.dout_oe_o, bus.frame_abort_o);
    end
    repeat (6) @(negedge clock);
    n_checks++;
    if (n_abort != 1 || n_done != 0) begin
      n_errors++;
      $display("FAIL abort_count: got abort=%0d done=%0d, required abort=1 done=0", n_abort, n_done);
    end
    clear_counts();
    drive_frame(12'h5A3, 26, 0, 12'h000, 0, "after_abort");
    repeat (8) @(negedge clock);
    n_checks++;
    if (n_done != 1 || n_abort != 0 || n_conv != 1) begin
      n_errors++;
      $display("FAIL after_abort_pulses: got conv=%0d done=%0d abort=%0d, required 1 1 0",
               n_conv, n_done, n_abort);
    end
  endtask

  task automatic test_sample_change();
    clear_counts();
    drive_frame(12'h000, 26, 5, 12'hFFF, 0, "sample_change");
    repeat (8) @(negedge clock);
    n_checks++;
    if (n_done != 1) begin
      n_errors++;
      $display("FAIL sample_change_done: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_cs_high_sclk();
    clear_counts();
    bus.cs_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sclk_i = 1'b1;
      repeat (HALF) @(negedge clock);
      bus.sclk_i = 1'b0;
      repeat (HALF) @(negedge clock);
    end
    $display("idle sclk burst: 20 cycles with cs_n high");
    n_checks++;
    if (n_oe_hi != 0) begin
      n_errors++;
      $display("FAIL cs_high_oe: got %0d oe cycles, required 0", n_oe_hi);
    end
    n_checks++;
    if (n_conv + n_done + n_abort != 0) begin
      n_errors++;
      $display("FAIL cs_high_pulses: got %0d pulses, required 0", n_conv + n_done + n_abort);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_frame(12'h6B9, 26, 0, 12'h000, 7, "reset_mid");
    #2;
    n_checks++;
    if (bus.dout_oe_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_oe_before: got %b, required 1", bus.dout_oe_o);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.dout_o, bus.dout_oe_o, bus.conv_start_o, bus.frame_done_o, bus.frame_abort_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got %b, required 00000",
               {bus.dout_o, bus.dout_oe_o, bus.conv_start_o, bus.frame_done_o, bus.frame_abort_o});
    end
    exp_q.delete();
    bus.cs_n_i = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    clear_counts();
    repeat (4) @(negedge clock);
    drive_frame(12'h3A7, 26, 0, 12'h000, 0, "after_reset");
    repeat (8) @(negedge clock);
    n_checks++;
    if (n_done != 1 || n_abort != 0 || n_conv != 1) begin
      n_errors++;
      $display("FAIL after_reset_pulses: got conv=%0d done=%0d abort=%0d, required 1 1 0",
               n_conv, n_done, n_abort);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    drive_frame(12'h001, 26, 0, 12'h000, 0, "b2b_001");
    repeat (3) @(negedge clock);
    drive_frame(12'h800, 26, 0, 12'h000, 0, "b2b_800");
    repeat (8) @(negedge clock);
    n_checks++;
    if (n_conv != 2 || n_done != 2 || n_abort != 0) begin
      n_errors++;
      $display("FAIL b2b_pulses: got conv=%0d done=%0d abort=%0d, required 2 2 0",
               n_conv, n_done, n_abort);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_scoreboard_left: got %0d entries, required 0", exp_q.size());
    end
  endtask

  initial begin
    bus.sclk_i   = 1'b0;
    bus.cs_n_i   = 1'b1;
    bus.sample_i = 12'h000;
    test_reset();
    test_full_frame();
    test_abort();
    test_sample_change();
    test_cs_high_sclk();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
